// File: rtl/irq_ctrl_if.sv
// CPU-side register window bus for the interrupt controller.
// The CPU (master) drives select/strobe/address/data, the controller returns read data.
interface irq_ctrl_if;
  logic       cs_n;
  logic       rw;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;

  modport master (output cs_n, rw, addr, wdata, input rdata);
  modport slave  (input cs_n, rw, addr, wdata, output rdata);
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller for the 6502 system: per-channel synchroniser, edge/level mode,
// pending latch, mask and lowest-index-wins priority, exposed as a 4-register window.
module irq_ctrl #(
  parameter int CHANNELS    = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] irq_in_n,
  irq_ctrl_if.slave           bus,
  output logic                irq_n
);

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q, sync_d;
  logic [CHANNELS-1:0] hist_q;
  logic [CHANNELS-1:0] latch_q, latch_d;
  logic [CHANNELS-1:0] mask_q, mask_d;
  logic [CHANNELS-1:0] mode_q, mode_d;
  logic                wr_prev_q;
  logic                irq_n_q, irq_n_d;

  logic [CHANNELS-1:0] s, fe, clr, pend_eff, pend_qual, wdata_ch;
  logic                wr_req, wr_commit;
  logic [2:0]          act_idx;
  logic                act_none;
  logic [7:0]          pend8, mask8, mode8, rdata_c;
  logic                unused_wdata;

  assign s        = sync_q[SYNC_STAGES-1];
  assign fe       = hist_q & ~s;
  assign wdata_ch = bus.wdata[CHANNELS-1:0];
  assign unused_wdata = ^bus.wdata;

  // The bus holds a write for many clocks; only its first cycle commits.
  assign wr_req    = ~bus.cs_n & ~bus.rw;
  assign wr_commit = wr_req & ~wr_prev_q;

  always_comb begin
    sync_d[0] = irq_in_n;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
    clr    = '0;
    if (wr_commit) begin
      case (bus.addr)
        2'd0:    clr    = wdata_ch;
        2'd1:    mask_d = wdata_ch;
        2'd2:    mode_d = wdata_ch;
        default: ;
      endcase
    end
    // A new edge beats a coincident write-1-to-clear.
    latch_d   = (latch_q & ~clr) | fe;
    pend_eff  = (mode_q & latch_q) | (~mode_q & ~s);
    pend_qual = pend_eff & mask_q;
    irq_n_d   = ~|pend_qual;
  end

  always_comb begin
    act_none = 1'b1;
    act_idx  = 3'd0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (pend_qual[i]) begin
        act_none = 1'b0;
        act_idx  = 3'(i);
      end
    end
  end

  always_comb begin
    pend8 = '0;
    mask8 = '0;
    mode8 = '0;
    pend8[CHANNELS-1:0] = pend_eff;
    mask8[CHANNELS-1:0] = mask_q;
    mode8[CHANNELS-1:0] = mode_q;
    case (bus.addr)
      2'd0:    rdata_c = pend8;
      2'd1:    rdata_c = mask8;
      2'd2:    rdata_c = mode8;
      default: rdata_c = {act_none, 4'b0000, act_idx};
    endcase
  end

  assign bus.rdata = rdata_c;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q    <= '1;
      hist_q    <= '1;
      latch_q   <= '0;
      mask_q    <= '0;
      mode_q    <= '0;
      wr_prev_q <= 1'b0;
      irq_n_q   <= 1'b1;
    end else begin
      sync_q    <= sync_d;
      hist_q    <= s;
      latch_q   <= latch_d;
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      wr_prev_q <= wr_req;
      irq_n_q   <= irq_n_d;
    end
  end

  assign irq_n = irq_n_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed and randomized bench for irq_ctrl against a cycle-level behavioural model.
module tb_irq_ctrl;
  localparam int CH = 6;
  localparam int SS = 2;

  logic          clock;
  logic          reset;
  logic [CH-1:0] irq_in_n;
  logic          irq_n;
  int            total;
  int            passed;
  int            failed;

  irq_ctrl_if bus();

  irq_ctrl #(.CHANNELS(CH), .SYNC_STAGES(SS)) dut (
    .clock    (clock),
    .reset    (reset),
    .irq_in_n (irq_in_n),
    .bus      (bus),
    .irq_n    (irq_n)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Model: line value as seen at each past edge (index 0 = newest sample).
  logic [CH-1:0] m_line [0:SS];
  logic [CH-1:0] m_latch, m_mask, m_mode;
  logic          m_irq_n, m_wr_prev;

  function automatic logic [CH-1:0] m_eff();
    // The synchronised view of a line is the sample taken SS edges ago.
    logic [CH-1:0] seen;
    seen = m_line[SS-1];
    return (m_mode & m_latch) | (~m_mode & ~seen);
  endfunction

  function automatic logic [7:0] m_read(input logic [1:0] a);
    logic [CH-1:0] e, q;
    logic [7:0]    r;
    e = m_eff();
    q = e & m_mask;
    case (a)
      2'd0: r = 8'(e);
      2'd1: r = 8'(m_mask);
      2'd2: r = 8'(m_mode);
      default: begin
        r = 8'h80;
        for (int i = 0; i < CH; i++) if (q[i] && r == 8'h80) r = 8'(i);
      end
    endcase
    return r;
  endfunction

  task automatic model_edge();
    logic [CH-1:0] fell, nxt;
    logic          commit;
    if (reset) begin
      for (int i = 0; i <= SS; i++) m_line[i] = '1;
      m_latch = '0; m_mask = '0; m_mode = '0;
      m_irq_n = 1'b1; m_wr_prev = 1'b0;
    end else begin
      fell    = m_line[SS] & ~m_line[SS-1];
      m_irq_n = ((m_eff() & m_mask) == '0);
      commit  = !bus.cs_n && !bus.rw && !m_wr_prev;
      nxt     = m_latch;
      if (commit) begin
        case (bus.addr)
          2'd0: nxt    = nxt & ~bus.wdata[CH-1:0];
          2'd1: m_mask = bus.wdata[CH-1:0];
          2'd2: m_mode = bus.wdata[CH-1:0];
          default: ;
        endcase
      end
      m_latch   = nxt | fell;
      m_wr_prev = !bus.cs_n && !bus.rw;
      for (int i = SS; i > 0; i--) m_line[i] = m_line[i-1];
      m_line[0] = irq_in_n;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clock);
    #1;
    check({tag, " irq_n"}, {7'b0, irq_n}, {7'b0, m_irq_n});
    check({tag, " rdata"}, bus.rdata, m_read(bus.addr));
  endtask

  task automatic read_chk(input logic [1:0] a, input logic [7:0] exp, input string tag);
    bus.addr = a;
    #1;
    check(tag, bus.rdata, exp);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    bus.cs_n = 1'b0; bus.rw = 1'b0; bus.addr = a; bus.wdata = d;
    step("wr");
    bus.cs_n = 1'b1; bus.rw = 1'b1;
    step("wr_idle");
  endtask

  int hold;
  int r;

  initial begin
    total = 0; passed = 0; failed = 0; hold = 0;
    reset = 1'b1; irq_in_n = '1;
    bus.cs_n = 1'b1; bus.rw = 1'b1; bus.addr = 2'd0; bus.wdata = 8'h00;
    #1;

    step("rst"); step("rst");
    reset = 1'b0;
    step("post_rst");
    check("rst irq_n", {7'b0, irq_n}, 8'h01);
    read_chk(2'd0, 8'h00, "rst PEND");
    read_chk(2'd1, 8'h00, "rst MASK");
    read_chk(2'd3, 8'h80, "rst ACTIVE");

    // Edge channel latency and clear.
    bus_write(2'd2, 8'h3F); bus_write(2'd1, 8'h3F);
    irq_in_n[2] = 1'b0; step("e1"); irq_in_n[2] = 1'b1;
    step("e2"); step("e3");
    check("edge lat early", {7'b0, irq_n}, 8'h01);
    step("e4");
    check("edge lat", {7'b0, irq_n}, 8'h00);
    read_chk(2'd3, 8'h02, "edge ACTIVE");
    read_chk(2'd0, 8'h04, "edge PEND");
    bus_write(2'd0, 8'h04);
    check("edge cleared irq_n", {7'b0, irq_n}, 8'h01);

    // Level channel.
    bus_write(2'd2, 8'h00); bus_write(2'd1, 8'h01);
    irq_in_n[0] = 1'b0; step("l1"); step("l2");
    check("level lat early", {7'b0, irq_n}, 8'h01);
    step("l3");
    check("level lat", {7'b0, irq_n}, 8'h00);
    bus_write(2'd0, 8'h01);
    read_chk(2'd0, 8'h01, "level W1C ignored");
    check("level irq held", {7'b0, irq_n}, 8'h00);
    irq_in_n[0] = 1'b1; step("lr1"); step("lr2"); step("lr3");
    check("level release", {7'b0, irq_n}, 8'h01);

    // Priority and mask.
    bus_write(2'd0, 8'h3F); bus_write(2'd2, 8'h3F); bus_write(2'd1, 8'h3F);
    irq_in_n[1] = 1'b0; irq_in_n[4] = 1'b0; step("p1"); irq_in_n = '1;
    step("p2"); step("p3"); step("p4");
    read_chk(2'd3, 8'h01, "prio ACTIVE 1");
    bus_write(2'd0, 8'h02);
    read_chk(2'd3, 8'h04, "prio ACTIVE 4");
    bus_write(2'd1, 8'h00);
    check("masked irq_n", {7'b0, irq_n}, 8'h01);
    read_chk(2'd0, 8'h10, "masked PEND");

    // Write held for 8 cycles with an edge arriving mid-hold.
    bus_write(2'd0, 8'h3F); bus_write(2'd1, 8'h3F);
    bus.cs_n = 1'b0; bus.rw = 1'b0; bus.addr = 2'd0; bus.wdata = 8'h08;
    for (int c = 1; c <= 8; c++) begin
      if (c == 5) irq_in_n[3] = 1'b0;
      step("hold");
    end
    bus.cs_n = 1'b1; bus.rw = 1'b1;
    step("hold_end");
    irq_in_n[3] = 1'b1;
    read_chk(2'd0, 8'h08, "held write PEND");

    // Set/clear collision.
    bus_write(2'd0, 8'h08);
    read_chk(2'd0, 8'h00, "coll pre PEND");
    irq_in_n[3] = 1'b0; step("c1"); step("c2");
    bus.cs_n = 1'b0; bus.rw = 1'b0; bus.addr = 2'd0; bus.wdata = 8'h08;
    step("c3");
    bus.cs_n = 1'b1; bus.rw = 1'b1; irq_in_n[3] = 1'b1;
    step("c4");
    read_chk(2'd0, 8'h08, "coll set wins");

    // Reset with all latches set.
    irq_in_n = '0; step("a1"); irq_in_n = '1;
    step("a2"); step("a3"); step("a4");
    read_chk(2'd0, 8'h3F, "all PEND");
    reset = 1'b1; step("rst2");
    check("rst2 irq_n", {7'b0, irq_n}, 8'h01);
    read_chk(2'd0, 8'h00, "rst2 PEND");

    // Line held low through reset yields exactly one edge.
    irq_in_n[5] = 1'b0;
    step("rst3");
    reset = 1'b0;
    bus_write(2'd2, 8'h20);
    step("h1");
    read_chk(2'd0, 8'h20, "held-low one edge");
    bus_write(2'd0, 8'h20);
    step("h2"); step("h3"); step("h4");
    read_chk(2'd0, 8'h00, "held-low no re-edge");
    irq_in_n[5] = 1'b1;
    step("h5");

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 5) == 0) irq_in_n = irq_in_n ^ CH'(1 << $urandom_range(0, CH - 1));
      if (hold > 0) begin
        hold--;
        if (hold == 0) begin bus.cs_n = 1'b1; bus.rw = 1'b1; end
      end else begin
        r = $urandom_range(0, 9);
        if (r < 3) begin
          bus.cs_n = 1'b0; bus.rw = 1'b0;
          bus.addr = 2'($urandom_range(0, 3));
          bus.wdata = 8'($urandom);
          hold = $urandom_range(1, 4);
        end else begin
          bus.cs_n = (r == 3) ? 1'b0 : 1'b1;
          bus.rw = 1'b1;
          bus.addr = 2'($urandom_range(0, 3));
        end
      end
      reset = ($urandom_range(0, 199) == 0);
      step("rnd");
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
